// File: rtl/line_buffer_ram.sv
// Multi-line circular pixel store: NUM_LINES line memories filled in rotation,
// read one column across all stored lines per access (lane 0 = oldest line).

module line_mem #(
  parameter int DW    = 24,
  parameter int DEPTH = 960,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Registered read sampled at the same edge as the write: read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module line_buffer_ram #(
  parameter int DATA_WIDTH = 24,
  parameter int LINE_WIDTH = 960,
  parameter int NUM_LINES  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            rd_en,
  input  logic [$clog2(LINE_WIDTH)-1:0]   rd_col,
  output logic [NUM_LINES*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_LINES-1:0]            rd_lane_valid,
  output logic                            rd_valid,
  input  logic                            line_release,
  output logic [$clog2(NUM_LINES+1)-1:0]  lines_avail,
  output logic [$clog2(NUM_LINES)-1:0]    wr_line
);
  localparam int LW = $clog2(NUM_LINES);
  localparam int CW = $clog2(NUM_LINES+1);
  localparam int AW = $clog2(LINE_WIDTH);

  typedef struct packed {
    logic [LW-1:0] ol;
    logic [CW-1:0] cnt;
    logic          col_ok;
  } rd_ctx_t;

  logic [LW-1:0] wl, ol;
  logic [AW-1:0] wc;
  logic [CW-1:0] cnt;
  logic          acc, complete, rel, col_ok;
  logic [CW:0]   ol_sum;
  logic [AW-1:0] raddr;
  rd_ctx_t       ctx_q;
  logic          rd_vld;
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] mem_rd;

  assign s_ready  = (cnt != CW'(NUM_LINES));
  assign acc      = s_valid & s_ready;
  assign complete = acc & (wc == AW'(LINE_WIDTH-1));
  assign rel      = line_release & (cnt != '0);

  // Oldest slot trails the write slot by the number of complete lines.
  assign ol_sum = (CW+1)'(wl) + (CW+1)'(NUM_LINES) - (CW+1)'(cnt);
  assign ol     = (ol_sum >= (CW+1)'(NUM_LINES)) ? LW'(ol_sum - (CW+1)'(NUM_LINES))
                                                 : LW'(ol_sum);

  assign col_ok = ({1'b0, rd_col} < (AW+1)'(LINE_WIDTH));
  assign raddr  = col_ok ? rd_col : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wl  <= '0;
      wc  <= '0;
      cnt <= '0;
    end else begin
      if (acc) begin
        if (complete) begin
          wc <= '0;
          wl <= (wl == LW'(NUM_LINES-1)) ? '0 : wl + LW'(1);
        end else begin
          wc <= wc + AW'(1);
        end
      end
      cnt <= cnt + CW'(complete) - CW'(rel);
    end
  end

  // Read context captured pre-update so lane mapping matches the data read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      ctx_q  <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) ctx_q <= '{ol: ol, cnt: cnt, col_ok: col_ok};
    end
  end

  for (genvar s = 0; s < NUM_LINES; s++) begin : g_slot
    line_mem #(.DW(DATA_WIDTH), .DEPTH(LINE_WIDTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (acc & (wl == LW'(s))),
      .waddr (wc),
      .wdata (s_data),
      .re    (rd_en),
      .raddr (raddr),
      .rdata (mem_rd[s])
    );
  end

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_lane
    logic [CW:0]   sum;
    logic [LW-1:0] sel;
    assign sum = (CW+1)'(ctx_q.ol) + (CW+1)'(k);
    assign sel = (sum >= (CW+1)'(NUM_LINES)) ? LW'(sum - (CW+1)'(NUM_LINES)) : LW'(sum);
    assign rd_lane_valid[k] = rd_vld & ctx_q.col_ok & (CW'(k) < ctx_q.cnt);
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_lane_valid[k] ? mem_rd[sel] : '0;
  end

  assign rd_valid    = rd_vld;
  assign lines_avail = cnt;
  assign wr_line     = wl;
endmodule

// File: tb/tb_line_buffer_ram.sv
// Directed bench for line_buffer_ram: fill, back-pressure, wrap, corner events, reset.

module tb_line_buffer_ram;
  localparam int DW = 24, LWID = 960, NL = 4;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           s_valid = 1'b0, s_ready;
  logic [DW-1:0]  s_data = '0;
  logic           rd_en = 1'b0;
  logic [9:0]     rd_col = '0;
  logic [NL*DW-1:0] rd_data;
  logic [NL-1:0]  rd_lane_valid;
  logic           rd_valid;
  logic           line_release = 1'b0;
  logic [2:0]     lines_avail;
  logic [1:0]     wr_line;

  int checks = 0, errors = 0;

  line_buffer_ram #(.DATA_WIDTH(DW), .LINE_WIDTH(LWID), .NUM_LINES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rd_en(rd_en), .rd_col(rd_col), .rd_data(rd_data), .rd_lane_valid(rd_lane_valid),
    .rd_valid(rd_valid), .line_release(line_release), .lines_avail(lines_avail),
    .wr_line(wr_line)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int k);
    return 32'(rd_data[k*DW +: DW]);
  endfunction

  task automatic write_line(input int ln, input int ncol, input bit rel_last);
    for (int c = 0; c < ncol; c++) begin
      if (!s_ready) begin
        chk("wr_ready", 32'(s_ready), 1);
        s_valid = 1'b0;
        return;
      end
      s_valid = 1'b1;
      s_data = DW'(ln*1000 + c);
      line_release = rel_last && (c == LWID-1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    line_release = 1'b0;
  endtask

  task automatic pulse_release();
    line_release = 1'b1;
    @(negedge clk);
    line_release = 1'b0;
  endtask

  task automatic rd(input int col);
    rd_en = 1'b1;
    rd_col = 10'(col);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_avail", 32'(lines_avail), 0);
    chk("rst_wrline", 32'(wr_line), 0);
    chk("rst_rdvalid", 32'(rd_valid), 0);
    chk("rst_mask", 32'(rd_lane_valid), 0);
    chk("rst_rdata", 32'(rd_data == '0), 1);
    chk("rst_ready", 32'(s_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill two lines
    write_line(0, LWID, 0);
    write_line(1, LWID, 0);
    chk("fill_avail", 32'(lines_avail), 2);
    chk("fill_wrline", 32'(wr_line), 2);
    rd(5);
    chk("fill_rdvalid", 32'(rd_valid), 1);
    chk("fill_l0", lane(0), 5);
    chk("fill_l1", lane(1), 1005);
    chk("fill_l2", lane(2), 0);
    chk("fill_l3", lane(3), 0);
    chk("fill_mask", 32'(rd_lane_valid), 32'b0011);
    @(negedge clk);
    chk("idle_rdvalid", 32'(rd_valid), 0);
    chk("idle_rdata", 32'(rd_data == '0), 1);

    // Out-of-range column
    rd(960);
    chk("oor_rdvalid", 32'(rd_valid), 1);
    chk("oor_mask", 32'(rd_lane_valid), 0);
    chk("oor_rdata", 32'(rd_data == '0), 1);

    // Back-pressure
    write_line(2, LWID, 0);
    write_line(3, LWID, 0);
    chk("bp_ready", 32'(s_ready), 0);
    chk("bp_avail", 32'(lines_avail), 4);
    chk("bp_wrline", 32'(wr_line), 0);
    line_release = 1'b1;
    rd(5);
    line_release = 1'b0;
    chk("rel_ready", 32'(s_ready), 1);
    chk("rel_avail", 32'(lines_avail), 3);
    chk("rel_rd_mask", 32'(rd_lane_valid), 32'b1111);
    chk("rel_rd_l0", lane(0), 5);
    chk("rel_rd_l3", lane(3), 3005);
    chk("slot0_wrline", 32'(wr_line), 0);
    write_line(4, LWID, 0);
    rd(7);
    chk("l4_l0", lane(0), 1007);
    chk("l4_l1", lane(1), 2007);
    chk("l4_l2", lane(2), 3007);
    chk("l4_l3", lane(3), 4007);

    // Wrap-around with one release per line
    for (int ln = 5; ln < 10; ln++) begin
      pulse_release();
      chk($sformatf("wrap_wrline%0d", ln), 32'(wr_line), 32'(ln % 4));
      write_line(ln, LWID, 0);
    end
    rd(959);
    chk("wrap_l0", lane(0), 6959);
    chk("wrap_l1", lane(1), 7959);
    chk("wrap_l2", lane(2), 8959);
    chk("wrap_l3", lane(3), 9959);
    chk("wrap_mask", 32'(rd_lane_valid), 32'b1111);

    // Completion and release on the same edge
    pulse_release();
    chk("sim_pre_avail", 32'(lines_avail), 3);
    write_line(10, LWID, 1);
    chk("sim_avail", 32'(lines_avail), 3);

    // Read the slot/column being written on the same edge (last pixel of line 11)
    write_line(11, LWID-1, 0);
    s_valid = 1'b1;
    s_data = DW'(11959);
    rd(959);
    s_valid = 1'b0;
    chk("rbw_l3", lane(3), 0);
    chk("rbw_l2", lane(2), 10959);
    chk("rbw_mask", 32'(rd_lane_valid), 32'b0111);
    chk("rbw_avail", 32'(lines_avail), 4);
    rd(959);
    chk("rbw_after_l3", lane(3), 11959);
    chk("rbw_after_mask", 32'(rd_lane_valid), 32'b1111);

    // Back-to-back reads
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_col = 10'(100 + i);
      @(negedge clk);
      chk($sformatf("b2b_vld%0d", i), 32'(rd_valid), 1);
      chk($sformatf("b2b_l0_%0d", i), lane(0), 32'(8100 + i));
    end
    rd_en = 1'b0;

    // Drain, then release with nothing stored
    repeat (4) pulse_release();
    chk("drain_avail", 32'(lines_avail), 0);
    pulse_release();
    chk("rel0_avail", 32'(lines_avail), 0);
    chk("rel0_ready", 32'(s_ready), 1);

    // Reset mid-line
    write_line(12, LWID, 0);
    write_line(13, LWID, 0);
    write_line(14, 300, 0);
    chk("mid_wrline", 32'(wr_line), 2);
    chk("mid_avail", 32'(lines_avail), 2);
    rst_n = 1'b0;
    #1;
    chk("mrst_avail", 32'(lines_avail), 0);
    chk("mrst_wrline", 32'(wr_line), 0);
    chk("mrst_ready", 32'(s_ready), 1);
    chk("mrst_rdvalid", 32'(rd_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_line(20, LWID, 0);
    chk("post_avail", 32'(lines_avail), 1);
    chk("post_wrline", 32'(wr_line), 1);
    rd(300);
    chk("post_l0", lane(0), 20300);
    chk("post_mask", 32'(rd_lane_valid), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_buffer_ram.md
# line_buffer_ram

Multi-line circular pixel store for the bicubic upscaler, the parametrised successor to the single-port 24-bit line SRAM. It accepts a pixel stream through a valid/ready write port and fills `NUM_LINES` line memories in rotation. It reads one column from every stored line in a single cycle, so the bicubic kernel gets a full vertical tap set per access. The downstream consumer frees the oldest line explicitly, and the block applies write back-pressure when every slot holds an unreleased complete line.

## Interface
- `DATA_WIDTH`, 24, bits per pixel (RGB888).
- `LINE_WIDTH`, 960, pixels per line (memory depth per line).
- `NUM_LINES`, 4, number of line slots (≥2); also the read lane count.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `s_valid` input 1: write pixel valid.
- `s_ready` output 1: write pixel accepted when `s_valid & s_ready`.
- `s_data` input DATA_WIDTH: write pixel.
- `rd_en` input 1: column read request.
- `rd_col` input $clog2(LINE_WIDTH): column to read.
- `rd_data` output NUM_LINES*DATA_WIDTH: lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the oldest line.
- `rd_lane_valid` output NUM_LINES: bit k set when lane k holds a complete line.
- `rd_valid` output 1: `rd_data`/`rd_lane_valid` valid this cycle.
- `line_release` input 1: free the oldest complete line.
- `lines_avail` output $clog2(NUM_LINES+1): count of complete, unreleased lines.
- `wr_line` output $clog2(NUM_LINES): slot currently being written.

## Operation
- State:
  - write slot `wl`;
  - write column `wc`;
  - complete-line count `cnt` (0..NUM_LINES);
  - oldest slot `ol = (wl - cnt) mod NUM_LINES`.
- `s_ready = (cnt != NUM_LINES)`. This is combinational from `cnt` only, with no dependence on `s_valid`.
- Accepted write:
  - `mem[wl][wc] <= s_data`; `wc++`.
  - At `wc == LINE_WIDTH-1`: `wc <= 0`, `wl <= (wl+1) mod NUM_LINES`, and a line-complete event fires.
- `cnt_next = cnt + complete - (line_release & cnt != 0)`.
  - A release with `cnt == 0` is ignored.
  - A completion and a release in the same cycle leave `cnt` unchanged.
- A full buffer (`cnt == NUM_LINES`) means `wl == ol`. `s_ready` is low there, so the oldest line is never overwritten.
- Read at the rising edge with `rd_en`:
  - Captures `ol` and `cnt` as they were before that edge's updates.
  - Lane k is sourced from slot `(ol+k) mod NUM_LINES` at column `rd_col`.
  - `rd_lane_valid[k] = (k < cnt)`.
  - Lanes with k ≥ cnt output zero.
- `rd_col ≥ LINE_WIDTH`: all lanes are zero and `rd_lane_valid` is zero. `rd_valid` still asserts.
- Read and write to the same slot and column in the same cycle: the read returns the pre-write content (read-before-write).
- `lines_avail = cnt`; `wr_line = wl`.
- Memory contents are not reset; only control state is.

## Timing
- Reset (asynchronous assert, synchronous release). Values while `rst_n` is low:
  - `wl = wc = cnt = 0`;
  - `rd_valid = 0`, `rd_data = 0`, `rd_lane_valid = 0`;
  - `lines_avail = 0`, `wr_line = 0`;
  - `s_ready = 1` (it follows `cnt = 0`).
- Reset mid-line discards the partial line and all stored lines. Nothing is written or released while `rst_n` is low.
- Write latency: data is readable by a read issued the cycle after acceptance.
- Line completion: `lines_avail` and `rd_lane_valid` reflect the new line one cycle after the last pixel is accepted.
- Read latency is 1 cycle: `rd_en` at edge N gives `rd_valid = 1` with data after edge N, held until edge N+1.
  - Back-to-back reads sustain 1 column per cycle.
  - Without `rd_en`, `rd_valid` returns to 0 and `rd_data` is zeroed.
- Release:
  - Takes effect at the edge it is sampled.
  - `s_ready` can rise in the next cycle.
  - A read issued on the same edge still sees the pre-release line set.
- Throughput: 1 pixel written and 1 column read per cycle, concurrently.

## Test plan
- Reset then fill: write 2×LINE_WIDTH pixels (value = line*1000+col).
  - `lines_avail = 2`.
  - Read column 5 → lane0 = 5, lane1 = 1005, `rd_lane_valid = 4'b0011`, lanes 2–3 = 0.
- Back-pressure: write 4 full lines with no release.
  - `s_ready = 0` after the last pixel and `lines_avail = 4`.
  - Pulse `line_release` → `s_ready = 1` the next cycle, `lines_avail = 3`.
  - The next line goes to slot 0.
- Wrap-around: stream 10 lines, releasing one per line after the 4th.
  - Read column 959 → lanes ordered oldest to newest (6xxx, 7xxx, 8xxx, 9xxx).
  - `wr_line` cycles 0→1→2→3→0.
- Simultaneous events:
  - Same-cycle line completion and release → `lines_avail` unchanged.
  - Release at `cnt = 0` → ignored.
  - Same-address read/write → old data returned.
- Read edge cases:
  - `rd_col = 960` → `rd_valid = 1`, data and mask zero.
  - `rd_en` held 8 cycles → 8 consecutive valid columns.
- Reset mid-line (after 300 pixels of line 2) → all control outputs zero and `s_ready = 1`. A new line is then written to slot 0.
